// File: rtl/z80_bank_port_sync_if.sv
// rtl/z80_bank_port_sync_if.sv - Z80 bus and bank-select bundle for the bank port stage
//
// Purpose: groups the raw Z80 bus inputs and the bank port outputs.
//   master : the Z80 bus side, which drives the strobes, address and data and observes the outputs
//   slave  : z80_bank_port_sync, which samples the bus and drives the bank select
// Signals:
//   AddrIO[3:0]  Z80 A7..A4
//   D1D0[1:0]    Z80 D1..D0
//   WR_N, RD_N, MREQ_N, IORQ_N   asynchronous active-low Z80 strobes
//   bank[1:0]    current bank select to the RAM decoder
//   bank_wr      one-cycle pulse on the cycle bank takes a new value
//   bus_conf     synced /MREQ and /IORQ both low
//   D_OUT[1:0]   readback data
//   D_OE         readback output enable

interface z80_bank_port_sync_if;
  logic [3:0] AddrIO;
  logic [1:0] D1D0;
  logic       WR_N;
  logic       RD_N;
  logic       MREQ_N;
  logic       IORQ_N;
  logic [1:0] bank;
  logic       bank_wr;
  logic       bus_conf;
  logic [1:0] D_OUT;
  logic       D_OE;

  modport master (
    output AddrIO, D1D0, WR_N, RD_N, MREQ_N, IORQ_N,
    input  bank, bank_wr, bus_conf, D_OUT, D_OE
  );

  modport slave (
    input  AddrIO, D1D0, WR_N, RD_N, MREQ_N, IORQ_N,
    output bank, bank_wr, bus_conf, D_OUT, D_OE
  );
endinterface

// File: rtl/z80_bank_port_sync.sv
// rtl/z80_bank_port_sync.sv - synchronised, glitch-filtered Z80 I/O bank port
//
// Purpose: the upstream stage of the 64K expansion RAM decoder.
//   - Samples the asynchronous Z80 strobes, address and data.
//   - Qualifies I/O writes to BANK_PORT.
//   - Commits exactly one bank value per I/O write cycle.
//   - Drives bank[1:0], which the RAM decoder turns into RAM_A15/A14.
// Optional feature: define BANK_READBACK_EN to build the I/O read path,
//   which returns the bank on D_OUT/D_OE. When it is undefined, D_OUT=0 and D_OE=0.
// Ports:
//   clk   system clock; all logic is on the rising edge
//   rst   synchronous, active-high reset
//   bus   z80_bank_port_sync_if.slave, which carries:
//           AddrIO, D1D0, WR_N, RD_N, MREQ_N, IORQ_N  (inputs)
//           bank, bank_wr, bus_conf, D_OUT, D_OE     (outputs)

module z80_bank_port_sync #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         STABLE_CYCLES = 2,
  parameter logic [3:0] BANK_PORT     = 4'h7,
  parameter logic [1:0] RESET_BANK    = 2'b01
) (
  input  logic                    clk,
  input  logic                    rst,
  z80_bank_port_sync_if.slave     bus
);

  localparam int CNT_W  = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, QUAL, COMMIT, HOLD} state_t;

  // Strobe bit order within each stage: {WR, RD, MREQ, IORQ}.
  logic [3:0] strb_sync [SYNC_STAGES];
  logic [3:0] addr_sync [SYNC_STAGES];
  logic [1:0] data_sync [SYNC_STAGES];

  logic       wr_s, rd_s, mreq_s, iorq_s;
  logic [3:0] addr_s;
  logic [1:0] data_s;
  logic       io_wr;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_load, cnt_inc, commit;

  logic [FILL_W-1:0] fill_cnt;
  logic              fill_done;
  logic              released;

  logic [1:0] bank_q;
  logic       bank_wr_q;
  logic       bus_conf_q;

  // The address and data chains have the same depth as the strobe chains,
  // so that all of them line up on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        strb_sync[i] <= '1;
        addr_sync[i] <= '1;
        data_sync[i] <= '1;
      end
    end else begin
      strb_sync[0] <= {bus.WR_N, bus.RD_N, bus.MREQ_N, bus.IORQ_N};
      addr_sync[0] <= bus.AddrIO;
      data_sync[0] <= bus.D1D0;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        strb_sync[i] <= strb_sync[i-1];
        addr_sync[i] <= addr_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  assign wr_s   = strb_sync[SYNC_STAGES-1][3];
  assign rd_s   = strb_sync[SYNC_STAGES-1][2];
  assign mreq_s = strb_sync[SYNC_STAGES-1][1];
  assign iorq_s = strb_sync[SYNC_STAGES-1][0];
  assign addr_s = addr_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  assign io_wr = !iorq_s && mreq_s && !wr_s && rd_s && (addr_s == BANK_PORT);

  // A write cycle still in progress when reset is released must not commit.
  // The chains hold reset ones (fake "inactive") until SYNC_STAGES real
  // samples have shifted in. Only after that can a released strobe arm the FSM.
  assign fill_done = (fill_cnt == FILL_W'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
      released <= 1'b0;
    end else begin
      if (!fill_done)
        fill_cnt <= fill_cnt + FILL_W'(1);
      if (fill_done && (iorq_s || wr_s))
        released <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (io_wr && released) begin
          state_nxt = QUAL;
          cnt_load  = 1'b1;
        end
      end
      QUAL: begin
        if (!io_wr)
          state_nxt = IDLE;
        else if (cnt == CNT_W'(STABLE_CYCLES)) begin
          commit    = 1'b1;
          state_nxt = COMMIT;
        end else
          cnt_inc = 1'b1;
      end
      COMMIT: state_nxt = HOLD;
      // Remain here for the rest of the I/O cycle, so one cycle commits only once.
      HOLD: begin
        if (iorq_s || wr_s)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bank and bank_wr are registered on entry to COMMIT. The new value and its
  // pulse therefore appear together during the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bank_q     <= RESET_BANK;
      bank_wr_q  <= 1'b0;
      bus_conf_q <= 1'b0;
    end else begin
      if (cnt_load)
        cnt <= CNT_W'(1);
      else if (cnt_inc)
        cnt <= cnt + CNT_W'(1);
      if (commit)
        bank_q <= data_s;
      bank_wr_q  <= commit;
      bus_conf_q <= !mreq_s && !iorq_s;
    end
  end

  assign bus.bank     = bank_q;
  assign bus.bank_wr  = bank_wr_q;
  assign bus.bus_conf = bus_conf_q;

`ifdef BANK_READBACK_EN
  logic       io_rd;
  logic [1:0] d_out_q;
  logic       d_oe_q;

  assign io_rd = !iorq_s && mreq_s && !rd_s && wr_s && (addr_s == BANK_PORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q <= 2'b00;
      d_oe_q  <= 1'b0;
    end else begin
      d_oe_q  <= io_rd;
      d_out_q <= io_rd ? bank_q : 2'b00;
    end
  end

  assign bus.D_OUT = d_out_q;
  assign bus.D_OE  = d_oe_q;
`else
  assign bus.D_OUT = 2'b00;
  assign bus.D_OE  = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bank_port_sync.sv
// tb/tb_z80_bank_port_sync.sv - scoreboard bench for z80_bank_port_sync

module tb_z80_bank_port_sync;

  localparam int MIN_HOLD = 3;  // raw-sampled write edges needed for a commit at default params

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  z80_bank_port_sync_if bif ();

  z80_bank_port_sync dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int         errors = 0;
  int         checks = 0;
  int         pulses = 0;
  int         p0;
  logic [1:0] exp_q [$];
  logic [1:0] model_bank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every bank_wr pulse must match the next expected commit.
  always @(negedge clk) begin
    logic [1:0] e;
    if (bif.bank_wr === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0)
        check("sb_unexpected_wr", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_bank", 32'(bif.bank), 32'(e));
      end
    end
  end

  task automatic bus_idle();
    bif.AddrIO = 4'h0;
    bif.D1D0   = 2'b00;
    bif.WR_N   = 1'b1;
    bif.RD_N   = 1'b1;
    bif.MREQ_N = 1'b1;
    bif.IORQ_N = 1'b1;
  endtask

  task automatic io_write(input logic [3:0] a, input logic [1:0] d, input int hold, input logic rd_low);
    @(posedge clk); #2;
    bif.AddrIO = a;
    bif.D1D0   = d;
    bif.IORQ_N = 1'b0;
    bif.WR_N   = 1'b0;
    bif.RD_N   = !rd_low;
    if (a == 4'h7 && hold >= MIN_HOLD && !rd_low) begin
      exp_q.push_back(d);
      model_bank = d;
    end
    repeat (hold) @(posedge clk);
    #2 bus_idle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    bus_idle();
    rst = 1'b1;
    model_bank = 2'b01;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bank", 32'(bif.bank), 32'h1);
    check("rst_bank_wr", 32'(bif.bank_wr), 32'h0);
    check("rst_d_oe", 32'(bif.D_OE), 32'h0);
    check("rst_d_out", 32'(bif.D_OUT), 32'h0);
    check("rst_bus_conf", 32'(bif.bus_conf), 32'h0);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // 2: write 10 to port 7 held 10 clocks; bank changes on edge 5
    @(posedge clk); #2;
    bif.AddrIO = 4'h7; bif.D1D0 = 2'b10; bif.IORQ_N = 1'b0; bif.WR_N = 1'b0;
    exp_q.push_back(2'b10);
    p0 = pulses;
    repeat (4) @(posedge clk);
    #1 check("t2_bank_before_edge5", 32'(bif.bank), 32'h1);
    @(posedge clk);
    #1 check("t2_bank_edge5", 32'(bif.bank), 32'h2);
    check("t2_wr_edge5", 32'(bif.bank_wr), 32'h1);
    model_bank = 2'b10;
    repeat (5) @(posedge clk);
    #1 check("t2_single_pulse", 32'(pulses - p0), 32'd1);
    #1 bus_idle();
    repeat (8) @(posedge clk);
    #1 check("t2_pulses_after_release", 32'(pulses - p0), 32'd1);

    // 3: wrong port
    p0 = pulses;
    io_write(4'h6, 2'b11, 10, 1'b0);
    check("t3_bank_wrong_port", 32'(bif.bank), 32'(model_bank));
    check("t3_no_pulse", 32'(pulses - p0), 32'd0);

    // 4: one-clock glitch, then one edge short of the threshold
    io_write(4'h7, 2'b11, 1, 1'b0);
    check("t4_glitch_bank", 32'(bif.bank), 32'(model_bank));
    io_write(4'h7, 2'b11, MIN_HOLD - 1, 1'b0);
    check("t4_short_bank", 32'(bif.bank), 32'(model_bank));
    check("t4_no_pulse", 32'(pulses - p0), 32'd0);

    // WR and RD both low is not a write
    io_write(4'h7, 2'b11, 10, 1'b1);
    check("wr_rd_both_bank", 32'(bif.bank), 32'(model_bank));

    // all values stored as written, at the minimum hold
    for (int v = 0; v < 4; v++) begin
      io_write(4'h7, 2'(v), MIN_HOLD, 1'b0);
      check("val_bank", 32'(bif.bank), 32'(v));
    end

    // 5: reset during QUAL with write held
    p0 = pulses;
    @(posedge clk); #2;
    bif.AddrIO = 4'h7; bif.D1D0 = 2'b11; bif.IORQ_N = 1'b0; bif.WR_N = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("t5_bank_rst", 32'(bif.bank), 32'h1);
    #1 rst = 1'b0;
    model_bank = 2'b01;
    repeat (10) @(posedge clk);
    #1 check("t5_bank_held", 32'(bif.bank), 32'h1);
    check("t5_no_pulse", 32'(pulses - p0), 32'd0);
    bus_idle();
    repeat (8) @(posedge clk);
    #1 check("t5_bank_released", 32'(bif.bank), 32'h1);
    io_write(4'h7, 2'b11, MIN_HOLD, 1'b0);
    check("t5_rearmed_bank", 32'(bif.bank), 32'h3);

    // 6: readback and bus conflict
    @(posedge clk); #2;
    bif.AddrIO = 4'h7; bif.IORQ_N = 1'b0; bif.RD_N = 1'b0;
    repeat (4) @(posedge clk);
`ifdef BANK_READBACK_EN
    #1 check("t6_d_oe", 32'(bif.D_OE), 32'h1);
    check("t6_d_out", 32'(bif.D_OUT), 32'h3);
`else
    #1 check("t6_d_oe", 32'(bif.D_OE), 32'h0);
    check("t6_d_out", 32'(bif.D_OUT), 32'h0);
`endif
    #1 bus_idle();
    repeat (4) @(posedge clk);
    #1 check("t6_d_oe_drop", 32'(bif.D_OE), 32'h0);
    #1;
    bif.AddrIO = 4'h7; bif.D1D0 = 2'b00;
    bif.MREQ_N = 1'b0; bif.IORQ_N = 1'b0; bif.WR_N = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("t6_bus_conf", 32'(bif.bus_conf), 32'h1);
    repeat (6) @(posedge clk);
    #1 check("t6_conf_bank", 32'(bif.bank), 32'h3);
    bus_idle();
    repeat (4) @(posedge clk);
    #1 check("t6_bus_conf_clear", 32'(bif.bus_conf), 32'h0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
